// File: rtl/series_approx_engine.sv
// series_approx_engine: fixed-point power-series evaluator, ln(x) with t = x-1 or exp(x) with t = x.
// Define SERIES_EARLY_TERM_EN to end a run once |term| <= eps_i.
module series_approx_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int N_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] eps_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       terms_o,
    output logic             overflow_o
);
    localparam int DW = 2 * WIDTH;
    localparam logic signed [DW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [DW-1:0] ONE     = DW'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] ONE_W = ONE[WIDTH-1:0];
`ifdef SERIES_EARLY_TERM_EN
    localparam logic EARLY_EN = 1'b1;
`else
    localparam logic EARLY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_TERM, S_ACC, S_POW, S_DONE} state_t;

    // Magnitude is round-half-up(2^FRAC / d): floor((2^(FRAC+1) + d) / 2d).
    function automatic logic signed [WIDTH-1:0] coef(input logic is_exp, input int unsigned n);
        logic [63:0] d;
        logic [63:0] mag;
        d = 64'd1;
        if (is_exp) begin
            for (int unsigned i = 2; i <= n; i++) d = d * 64'(i);
        end else begin
            d = 64'(n);
        end
        mag = ((64'd1 << (FRAC + 1)) + d) / (d << 1);
        return (!is_exp && (n % 2 == 0)) ? -WIDTH'(mag) : WIDTH'(mag);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic ovf_of(input logic signed [DW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    logic signed [WIDTH-1:0] ln_c  [16];
    logic signed [WIDTH-1:0] exp_c [16];
    for (genvar g = 0; g < 16; g++) begin : g_coef
        if (g < N_MAX) begin : g_used
            assign ln_c[g]  = coef(1'b0, g + 1);
            assign exp_c[g] = coef(1'b1, g + 1);
        end else begin : g_unused
            assign ln_c[g]  = '0;
            assign exp_c[g] = '0;
        end
    end

    state_t                  state;
    logic                    mode_r;
    logic signed [WIDTH-1:0] x_r;
    logic [WIDTH-1:0]        eps_r;
    logic signed [WIDTH-1:0] t, p, term, y;
    logic [3:0]              n;
    logic                    ovf;

    logic signed [DW-1:0]    t_wide, term_wide, pow_wide, sum_wide;
    logic signed [WIDTH-1:0] c_sel, t_prep;
    logic [WIDTH-1:0]        term_mag;
    logic                    stop;

    always_comb begin
        c_sel     = mode_r ? exp_c[n - 4'd1] : ln_c[n - 4'd1];
        t_wide    = DW'(x_r) - ONE;
        t_prep    = mode_r ? x_r : sat(t_wide);
        term_wide = (DW'(p) * DW'(c_sel)) >>> FRAC;
        pow_wide  = (DW'(p) * DW'(t)) >>> FRAC;
        sum_wide  = DW'(y) + DW'(term);
        term_mag  = term[WIDTH-1] ? -term : term;
        stop      = (n == 4'(N_MAX)) || (EARLY_EN && (term_mag <= eps_r));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            terms_o    <= '0;
            overflow_o <= 1'b0;
            mode_r     <= 1'b0;
            x_r        <= '0;
            eps_r      <= '0;
            t          <= '0;
            p          <= '0;
            term       <= '0;
            y          <= '0;
            n          <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    mode_r <= mode_i;
                    x_r    <= x_i;
                    eps_r  <= eps_i;
                    busy_o <= 1'b1;
                    state  <= S_PREP;
                end
                S_PREP: begin
                    t     <= t_prep;
                    p     <= t_prep;
                    n     <= 4'd1;
                    y     <= mode_r ? ONE_W : '0;
                    ovf   <= !mode_r && ovf_of(t_wide);
                    state <= S_TERM;
                end
                S_TERM: begin
                    term  <= sat(term_wide);
                    ovf   <= ovf | ovf_of(term_wide);
                    state <= S_ACC;
                end
                S_ACC: begin
                    y   <= sat(sum_wide);
                    ovf <= ovf | ovf_of(sum_wide);
                    // Outputs load on the way into DONE so they are valid while done_o is high.
                    if (stop) begin
                        result_o   <= sat(sum_wide);
                        terms_o    <= n;
                        overflow_o <= ovf | ovf_of(sum_wide);
                        done_o     <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_POW;
                    end
                end
                S_POW: begin
                    p     <= sat(pow_wide);
                    ovf   <= ovf | ovf_of(pow_wide);
                    n     <= n + 4'd1;
                    state <= S_TERM;
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_series_approx_engine.sv
// Testbench for series_approx_engine: directed vectors plus randomized runs against a
// plain-arithmetic series model; honours SERIES_EARLY_TERM_EN.
module tb_series_approx_engine;
`ifdef SERIES_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
    localparam logic [15:0] LN_RES = 16'h0678;
    localparam int          LN_N   = 6;
    localparam int          ONE_N  = 1;
`else
    localparam bit EARLY = 1'b0;
    localparam logic [15:0] LN_RES = 16'h067A;
    localparam int          LN_N   = 8;
    localparam int          ONE_N  = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [15:0] x_i = '0;
    logic [15:0] eps_i = '0;
    logic        busy_o, done_o, overflow_o;
    logic [15:0] result_o;
    logic [3:0]  terms_o;

    int checks = 0;
    int errors = 0;

    series_approx_engine #(.WIDTH(16), .FRAC(12), .N_MAX(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .x_i(x_i),
        .eps_i(eps_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .terms_o(terms_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Series coefficient from its definition: 1/n (alternating) or 1/n!, in Q12.
    function automatic longint coef_m(input bit m, input int k);
        real    d;
        longint c;
        d = 1.0;
        if (m) for (int i = 2; i <= k; i++) d = d * i;
        else d = k;
        c = longint'($rtoi($floor(4096.0 / d + 0.5)));
        if (!m && (k % 2 == 0)) c = -c;
        return c;
    endfunction

    function automatic longint floor_q(input longint v);
        longint q;
        q = v / 4096;
        if (v < 0 && q * 4096 != v) q = q - 1;
        return q;
    endfunction

    task automatic sat_into(input longint v, inout bit ov, output longint r);
        if (v > 32767) begin r = 32767; ov = 1'b1; end
        else if (v < -32768) begin r = -32768; ov = 1'b1; end
        else r = v;
    endtask

    task automatic model(input bit m, input longint x, input longint eps,
                         output longint y, output int nt, output bit ov);
        longint t, p, term, mag;
        ov = 1'b0;
        sat_into(m ? x : x - 4096, ov, t);
        p  = t;
        y  = m ? 4096 : 0;
        nt = 0;
        for (int k = 1; k <= 8; k++) begin
            sat_into(floor_q(p * coef_m(m, k)), ov, term);
            sat_into(y + term, ov, y);
            nt  = k;
            mag = (term < 0) ? -term : term;
            if (k == 8) break;
            if (EARLY && mag <= eps) break;
            sat_into(floor_q(p * t), ov, p);
        end
    endtask

    // One run; lat is the cycle of the done pulse counted from the start edge (+1), -1 on timeout.
    task automatic run_once(input bit m, input logic [15:0] x, input logic [15:0] eps,
                            output logic [15:0] res, output logic [3:0] trm,
                            output logic ov, output int lat);
        @(negedge clk);
        mode_i = m; x_i = x; eps_i = eps; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin lat = c; break; end
        end
        res = result_o; trm = terms_o; ov = overflow_o;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (result_o !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result_o); end
        checks++; if (terms_o !== 4'h0) begin errors++; $display("FAIL reset_terms got %0d want 0", terms_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    endtask

    task automatic test_ln_vector();
        logic [15:0] res; logic [3:0] trm; logic ov; int lat;
        run_once(1'b0, 16'h1800, 16'h0010, res, trm, ov, lat);
        checks++; if (res !== LN_RES) begin errors++; $display("FAIL ln_result got %h want %h", res, LN_RES); end
        checks++; if (trm !== 4'(LN_N)) begin errors++; $display("FAIL ln_terms got %0d want %0d", trm, LN_N); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ln_ovf got %b want 0", ov); end
        checks++; if (lat !== 3 * LN_N + 1) begin errors++; $display("FAIL ln_latency got %0d want %0d", lat, 3 * LN_N + 1); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ln_busy_in_done got %b want 1", busy_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL ln_after_done got done=%b busy=%b want 0/0", done_o, busy_o); end
        run_once(1'b0, 16'h1000, 16'h0000, res, trm, ov, lat);
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL ln_one_result got %h want 0000", res); end
        checks++; if (trm !== 4'(ONE_N)) begin errors++; $display("FAIL ln_one_terms got %0d want %0d", trm, ONE_N); end
        checks++; if (lat !== 3 * ONE_N + 1) begin errors++; $display("FAIL ln_one_latency got %0d want %0d", lat, 3 * ONE_N + 1); end
    endtask

    task automatic test_exp_vectors();
        logic [15:0] res; logic [3:0] trm; logic ov; int lat;
        run_once(1'b1, 16'h1000, 16'h0000, res, trm, ov, lat);
        checks++; if (res !== 16'h2B7F) begin errors++; $display("FAIL exp1_result got %h want 2b7f", res); end
        checks++; if (trm !== 4'd8) begin errors++; $display("FAIL exp1_terms got %0d want 8", trm); end
        run_once(1'b1, 16'h0000, 16'h0000, res, trm, ov, lat);
        checks++; if (res !== 16'h1000) begin errors++; $display("FAIL exp0_result got %h want 1000", res); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL exp0_ovf got %b want 0", ov); end
    endtask

    task automatic test_overflow();
        logic [15:0] res; logic [3:0] trm; logic ov; int lat;
        run_once(1'b1, 16'h3000, 16'h0000, res, trm, ov, lat);
        checks++; if (res !== 16'h7FFF) begin errors++; $display("FAIL ovf_result got %h want 7fff", res); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ov); end
        run_once(1'b0, 16'h1800, 16'h0010, res, trm, ov, lat);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", ov); end
        checks++; if (res !== LN_RES) begin errors++; $display("FAIL ovf_next_result got %h want %h", res, LN_RES); end
    endtask

    task automatic test_random();
        logic [15:0] res, x, eps; logic [3:0] trm; logic ov, m; int lat, nt; longint y; bit mov;
        for (int i = 0; i < 40; i++) begin
            m   = 1'($urandom_range(0, 1));
            x   = (i % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 16'h2400));
            eps = 16'($urandom_range(0, 300));
            model(m, longint'($signed(x)), longint'(eps), y, nt, mov);
            run_once(m, x, eps, res, trm, ov, lat);
            checks++;
            if (res !== 16'(y) || trm !== 4'(nt) || ov !== mov || lat !== 3 * nt + 1) begin
                errors++;
                $display("FAIL rand_%0d m=%b x=%h eps=%h got res=%h n=%0d ov=%b lat=%0d want res=%h n=%0d ov=%b lat=%0d",
                         i, m, x, eps, res, trm, ov, lat, 16'(y), nt, mov, 3 * nt + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [15:0] first_res = '0;
        @(negedge clk);
        mode_i = 1'b1; x_i = 16'h1000; eps_i = 16'h0000; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin start_i = 1'b1; mode_i = 1'b0; x_i = 16'h3000; end
            if (c == 6) start_i = 1'b0;
            if (done_o === 1'b1) begin
                dones++;
                if (dones == 1) first_res = result_o;
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        checks++; if (first_res !== 16'h2B7F) begin errors++; $display("FAIL ignore_result got %h want 2b7f", first_res); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [15:0] r2 = '0;
        @(negedge clk);
        mode_i = 1'b1; x_i = 16'h1000; eps_i = 16'h0000; start_i = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (d1 < 0) d1 = c;
                else begin d2 = c; r2 = result_o; start_i = 1'b0; break; end
            end
        end
        start_i = 1'b0;
        checks++; if (d2 - d1 !== 26 || d1 < 0) begin
            errors++; $display("FAIL b2b_spacing got %0d want 26", d2 - d1); end
        checks++; if (r2 !== 16'h2B7F) begin errors++; $display("FAIL b2b_result got %h want 2b7f", r2); end
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        logic [15:0] res; logic [3:0] trm; logic ov; int lat;
        @(negedge clk);
        mode_i = 1'b0; x_i = 16'h1800; eps_i = 16'h0000; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 16'h0 || terms_o !== 4'h0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_async got busy=%b done=%b res=%h n=%0d ov=%b want all 0",
                     busy_o, done_o, result_o, terms_o, overflow_o);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
        run_once(1'b0, 16'h1800, 16'h0010, res, trm, ov, lat);
        checks++; if (res !== LN_RES || trm !== 4'(LN_N)) begin
            errors++; $display("FAIL abort_rerun got res=%h n=%0d want res=%h n=%0d", res, trm, LN_RES, LN_N); end
    endtask

    initial begin
        test_reset();
        test_ln_vector();
        test_exp_vectors();
        test_overflow();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
